// File: rtl/vx_commit_lock_arb_pkg.sv
// ---------------------------------------------------------------------------
// VX_gpu_pkg
//
// Purpose : Shared types and helpers for the commit lock arbiter slice.
//           Holds the arbiter FSM state enum, the width of the optional
//           lock-stall performance counter and a modular index helper used
//           by the round-robin picker.
//
// Contents:
//   commit_lock_state_e : UNLOCKED / LOCKED arbiter state
//   PERF_CNT_W          : width of the lock-stall counter (wraps at 2^32)
//   rr_offset()         : (base + off) mod n for base, off < n
// ---------------------------------------------------------------------------
package VX_gpu_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } commit_lock_state_e;

    localparam int PERF_CNT_W = 32;

    // Both operands are below n, so one conditional subtract wraps the sum
    // without needing a divider.
    function automatic int rr_offset(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        if (sum >= n) begin
            sum = sum - n;
        end
        return sum;
    endfunction

endpackage

// File: rtl/vx_commit_lock_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// VX_rr_pick
//
// Purpose : Purely combinational round-robin picker. Scans the request mask
//           starting at ptr_i, wrapping past N-1 back to 0, and returns the
//           first set request as both a one-hot grant and a binary index.
//
// Ports   :
//   valid_i [N]    : request mask
//   ptr_i   [IDXW] : index with highest priority this cycle (must be < N)
//   grant_o [N]    : one-hot grant, all zero when no request is set
//   index_o [IDXW] : binary index of the granted request (0 when none)
//   any_o          : at least one request is set
// ---------------------------------------------------------------------------
module VX_rr_pick
    import VX_gpu_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    valid_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [IDXW-1:0] index_o,
    output logic            any_o
);

    logic [IDXW-1:0] cand;

    // Walk the requesters in priority order from the pointer; the first
    // set request wins and later candidates are ignored once any_o is set.
    always_comb begin
        grant_o = '0;
        index_o = '0;
        any_o   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDXW'(rr_offset(int'(ptr_i), k, N));
            if (!any_o && valid_i[cand]) begin
                any_o         = 1'b1;
                grant_o[cand] = 1'b1;
                index_o       = cand;
            end
        end
    end

endmodule

// File: rtl/vx_commit_lock_arb.sv
// ---------------------------------------------------------------------------
// vx_commit_lock_arb
//
// Purpose : Commit arbiter for NUM_INPUTS execute-unit requesters feeding a
//           single registered output slot. Single-beat commits are
//           arbitrated round-robin; a multi-beat commit locks the arbiter
//           to its source until the eop beat is accepted so packets never
//           interleave. Output latency is one cycle and the slot sustains
//           one beat per cycle when draining and loading together.
//
// Parameters:
//   NUM_INPUTS : number of requesters (2..8)
//   DATAW      : payload width, excluding sop/eop
//
// Ports   :
//   clk, reset               : rising-edge clock, async active-high reset
//   valid_in/sop_in/eop_in   : per-requester beat valid and framing
//   data_in                  : per-requester payload, requester i at
//                              [i*DATAW +: DATAW]
//   ready_in                 : per-requester accept (beat taken when
//                              ready_in[i] && valid_in[i])
//   valid_out/data_out/
//   sop_out/eop_out/sel_out  : registered output beat and its source index
//   ready_out                : downstream accept
//   perf_lock_stalls         : (COMMIT_ARB_PERF_EN only) cycles spent
//                              locked while some other requester waited
//
// Configuration macro: COMMIT_ARB_PERF_EN adds the perf_lock_stalls port
//                      and its counter; the default build has neither.
// ---------------------------------------------------------------------------
module vx_commit_lock_arb
    import VX_gpu_pkg::*;
#(
    parameter  int NUM_INPUTS = 4,
    parameter  int DATAW      = 64,
    localparam int SELW       = $clog2(NUM_INPUTS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_INPUTS-1:0]         valid_in,
    input  logic [NUM_INPUTS*DATAW-1:0]   data_in,
    input  logic [NUM_INPUTS-1:0]         sop_in,
    input  logic [NUM_INPUTS-1:0]         eop_in,
    output logic [NUM_INPUTS-1:0]         ready_in,
    output logic                          valid_out,
    output logic [DATAW-1:0]              data_out,
    output logic                          sop_out,
    output logic                          eop_out,
    output logic [SELW-1:0]               sel_out,
    input  logic                          ready_out
`ifdef COMMIT_ARB_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0]         perf_lock_stalls
`endif
);

    // Arbiter state
    commit_lock_state_e    state_q, state_d;
    logic [SELW-1:0]       owner_q, owner_d;
    logic [SELW-1:0]       rr_ptr_q, rr_ptr_d;

    // Output slot
    logic                  valid_q, valid_d;
    logic [DATAW-1:0]      data_q, data_d;
    logic                  sop_q, sop_d;
    logic                  eop_q, eop_d;
    logic [SELW-1:0]       sel_q, sel_d;

    // Arbitration signals
    logic [NUM_INPUTS-1:0] owner_mask;
    logic [NUM_INPUTS-1:0] cand_valid;
    logic [NUM_INPUTS-1:0] grant_oh;
    logic [SELW-1:0]       grant_idx;
    logic                  grant_any;
    logic                  slot_free;
    logic                  accept;
    logic [DATAW-1:0]      gnt_data;
    logic                  gnt_sop;
    logic                  gnt_eop;

    // While locked only the owner may compete; masking the request vector
    // lets the same round-robin picker serve both states, since a single
    // set bit is found regardless of where the scan starts.
    always_comb begin
        owner_mask          = '0;
        owner_mask[owner_q] = 1'b1;
        cand_valid          = (state_q == LOCKED) ? (valid_in & owner_mask) : valid_in;
    end

    VX_rr_pick #(
        .N    (NUM_INPUTS),
        .IDXW (SELW)
    ) u_rr_pick (
        .valid_i (cand_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_oh),
        .index_o (grant_idx),
        .any_o   (grant_any)
    );

    // The slot can take a new beat when empty or when its current beat
    // leaves this same cycle. ready_in is forced low during reset so no
    // requester believes a beat was taken while the slot is being cleared.
    always_comb begin
        slot_free = !valid_q || ready_out;
        accept    = grant_any && slot_free;
        ready_in  = reset ? '0 : (grant_oh & {NUM_INPUTS{slot_free}});
    end

    // grant_oh is one-hot, so an AND-OR mux picks the granted beat without
    // a wide variable part-select.
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (grant_oh[i]) begin
                gnt_data = data_in[i*DATAW +: DATAW];
            end
        end
        gnt_sop = |(sop_in & grant_oh);
        gnt_eop = |(eop_in & grant_oh);
    end

    // Next-state logic for the lock FSM, round-robin pointer and output
    // slot. sop is carried through but never steers the FSM: only eop ends
    // ownership, so a packet missing its sop is handled identically. An idle
    // drain only clears valid; the FSM and pointer keep their values.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        valid_d  = valid_q;
        data_d   = data_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        sel_d    = sel_q;

        if (accept) begin
            valid_d = 1'b1;
            data_d  = gnt_data;
            sop_d   = gnt_sop;
            eop_d   = gnt_eop;
            sel_d   = grant_idx;
            if (gnt_eop) begin
                state_d  = UNLOCKED;
                rr_ptr_d = (grant_idx == SELW'(NUM_INPUTS - 1)) ? '0 : (grant_idx + 1'b1);
            end else begin
                state_d = LOCKED;
                owner_d = grant_idx;
            end
        end else if (ready_out) begin
            valid_d = 1'b0;
        end
    end

    // State and output slot registers; reset clears everything
    // asynchronously, which also drops any lock held mid-packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= UNLOCKED;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            sel_q    <= sel_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign sop_out   = sop_q;
    assign eop_out   = eop_q;
    assign sel_out   = sel_q;

`ifdef COMMIT_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] perf_q, perf_d;
    logic                  stall_seen;

    // A stall is any cycle in which the lock keeps another valid requester
    // out. The counter wraps naturally at its width.
    always_comb begin
        stall_seen = (state_q == LOCKED) && (|(valid_in & ~owner_mask));
        perf_d     = perf_q;
        if (stall_seen) begin
            perf_d = perf_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_lock_stalls = perf_q;
`else
    // Default build carries no lock-stall counter.
`endif

endmodule

// File: tb/tb_vx_commit_lock_arb.sv
// ---------------------------------------------------------------------------
// tb_vx_commit_lock_arb
//
// Self-checking bench for vx_commit_lock_arb with NUM_INPUTS=4, DATAW=64.
// Directed scenarios exercise reset, round-robin, locking, back-pressure,
// reset mid-packet, fairness and pointer wrap; a randomized run compares
// the DUT against a transaction-level model of the arbitration rules.
// Define COMMIT_ARB_PERF_EN to also check the lock-stall counter.
// ---------------------------------------------------------------------------
module tb_vx_commit_lock_arb;

    localparam int NI = 4;
    localparam int DW = 64;

    logic            clk;
    logic            reset;
    logic [NI-1:0]   validIn;
    logic [NI*DW-1:0] dataIn;
    logic [NI-1:0]   sopIn;
    logic [NI-1:0]   eopIn;
    logic [NI-1:0]   readyIn;
    logic            validOut;
    logic [DW-1:0]   dataOut;
    logic            sopOut;
    logic            eopOut;
    logic [1:0]      selOut;
    logic            readyOut;
`ifdef COMMIT_ARB_PERF_EN
    logic [31:0]     perfLockStalls;
`endif

    int testsRun;
    int testsFailed;

    // Reference model state: arbitration rules in plain integer terms
    int          mRr;
    bit          mLocked;
    int          mOwner;
    bit          mSlotValid;
    int          mSlotSrc;
    logic [63:0] mSlotData;
    bit          mSlotSop;
    bit          mSlotEop;
    int unsigned mPerf;

    vx_commit_lock_arb #(
        .NUM_INPUTS (NI),
        .DATAW      (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (validIn),
        .data_in   (dataIn),
        .sop_in    (sopIn),
        .eop_in    (eopIn),
        .ready_in  (readyIn),
        .valid_out (validOut),
        .data_out  (dataOut),
        .sop_out   (sopOut),
        .eop_out   (eopOut),
        .sel_out   (selOut),
        .ready_out (readyOut)
`ifdef COMMIT_ARB_PERF_EN
        ,
        .perf_lock_stalls (perfLockStalls)
`endif
    );

    // 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the bench always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e, input logic r);
        validIn  = v;
        sopIn    = s;
        eopIn    = e;
        readyOut = r;
    endtask

    task automatic setData(input int i, input logic [63:0] value);
        dataIn[i*DW +: DW] = value;
    endtask

    task automatic defaultData();
        for (int i = 0; i < NI; i++) begin
            setData(i, 64'hC0DE_0000_0000_0000 + 64'(i));
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
        dataIn = '0;
        tick();
        tick();
        reset      = 1'b0;
        mRr        = 0;
        mLocked    = 0;
        mOwner     = 0;
        mSlotValid = 0;
        mSlotSrc   = 0;
        mSlotData  = '0;
        mSlotSop   = 0;
        mSlotEop   = 0;
        mPerf      = 0;
    endtask

    // Model: index the arbitration rules would grant for this request mask
    function automatic int modelPick(input logic [3:0] v);
        if (mLocked) begin
            return v[mOwner] ? mOwner : -1;
        end
        for (int k = 0; k < NI; k++) begin
            if (v[(mRr + k) % NI]) return (mRr + k) % NI;
        end
        return -1;
    endfunction

    task automatic test_reset();
        doReset();
        setData(2, 64'hDEAD_BEEF_0000_0002);
        applyStimulus(4'b0100, 4'b0100, 4'b0100, 1'b0);
        tick();
        testsRun++; if ({validOut, selOut} !== 3'b110) begin testsFailed++; $display("[TB] FAIL reset_preload got=%b exp=%b", {validOut, selOut}, 3'b110); end
        applyStimulus(4'b1111, 4'b1111, 4'b1111, 1'b0);
        reset = 1'b1;
        #1;
        testsRun++; if (validOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid got=%b exp=0", validOut); end
        testsRun++; if (dataOut !== 64'h0) begin testsFailed++; $display("[TB] FAIL reset_data got=%h exp=0", dataOut); end
        testsRun++; if ({sopOut, eopOut} !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_sopeop got=%b exp=00", {sopOut, eopOut}); end
        testsRun++; if (selOut !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_sel got=%0d exp=0", selOut); end
        testsRun++; if (readyIn !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_ready got=%b exp=0000", readyIn); end
`ifdef COMMIT_ARB_PERF_EN
        testsRun++; if (perfLockStalls !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_perf got=%0d exp=0", perfLockStalls); end
`endif
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_beat();
        int exp;
        logic [3:0] expMask;
        doReset();
        defaultData();
        applyStimulus(4'b0101, 4'b0101, 4'b0101, 1'b1);
        #1;
        for (int i = 0; i < 4; i++) begin
            exp     = (i % 2 == 0) ? 0 : 2;
            expMask = 4'b0001 << exp;
            testsRun++; if (readyIn !== expMask) begin testsFailed++; $display("[TB] FAIL rr_ready[%0d] got=%b exp=%b", i, readyIn, expMask); end
            tick();
            testsRun++; if ({validOut, selOut, dataOut} !== {1'b1, 2'(exp), 64'hC0DE_0000_0000_0000 + 64'(exp)}) begin testsFailed++; $display("[TB] FAIL rr_beat[%0d] got v=%b sel=%0d d=%h exp sel=%0d", i, validOut, selOut, dataOut, exp); end
        end
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
        tick();
        testsRun++; if (validOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_drain got=%b exp=0", validOut); end
        applyStimulus(4'b1001, 4'b1001, 4'b1001, 1'b1);
        #1;
        testsRun++; if (readyIn !== 4'b1000) begin testsFailed++; $display("[TB] FAIL idle_keeps_ptr got=%b exp=1000", readyIn); end
        tick();
    endtask

    task automatic test_lock_packet();
        doReset();
        defaultData();
        applyStimulus(4'b0001, 4'b0001, 4'b0001, 1'b1);
        tick();
        testsRun++; if ({validOut, selOut} !== 3'b100) begin testsFailed++; $display("[TB] FAIL lock_pre got=%b exp=100", {validOut, selOut}); end
        for (int b = 0; b < 3; b++) begin
            validIn  = 4'b0011;
            sopIn    = {2'b00, (b == 0), 1'b1};
            eopIn    = {2'b00, (b == 2), 1'b1};
            setData(1, 64'hB0 + 64'(b));
            #1;
            testsRun++; if (readyIn !== 4'b0010) begin testsFailed++; $display("[TB] FAIL lock_ready[%0d] got=%b exp=0010", b, readyIn); end
            tick();
            testsRun++; if ({validOut, selOut, dataOut, eopOut} !== {1'b1, 2'd1, 64'hB0 + 64'(b), (b == 2)}) begin testsFailed++; $display("[TB] FAIL lock_beat[%0d] got sel=%0d d=%h eop=%b", b, selOut, dataOut, eopOut); end
        end
        validIn = 4'b0001;
        #1;
        testsRun++; if (readyIn !== 4'b0001) begin testsFailed++; $display("[TB] FAIL unlock_ready got=%b exp=0001", readyIn); end
        tick();
        testsRun++; if ({validOut, selOut} !== 3'b100) begin testsFailed++; $display("[TB] FAIL unlock_beat got=%b exp=100", {validOut, selOut}); end
`ifdef COMMIT_ARB_PERF_EN
        testsRun++; if (perfLockStalls !== 32'd2) begin testsFailed++; $display("[TB] FAIL lock_perf got=%0d exp=2", perfLockStalls); end
`endif
    endtask

    task automatic test_backpressure();
        doReset();
        setData(0, 64'hA5);
        setData(1, 64'h5A);
        applyStimulus(4'b0001, 4'b0001, 4'b0001, 1'b0);
        #1;
        testsRun++; if (readyIn !== 4'b0001) begin testsFailed++; $display("[TB] FAIL bp_load got=%b exp=0001", readyIn); end
        tick();
        applyStimulus(4'b0010, 4'b0010, 4'b0010, 1'b0);
        for (int c = 0; c < 4; c++) begin
            #1;
            testsRun++; if (readyIn !== 4'b0000) begin testsFailed++; $display("[TB] FAIL bp_ready[%0d] got=%b exp=0000", c, readyIn); end
            testsRun++; if ({validOut, selOut, dataOut} !== {1'b1, 2'd0, 64'hA5}) begin testsFailed++; $display("[TB] FAIL bp_hold[%0d] got v=%b sel=%0d d=%h exp d=a5", c, validOut, selOut, dataOut); end
            tick();
        end
        readyOut = 1'b1;
        #1;
        testsRun++; if (readyIn !== 4'b0010) begin testsFailed++; $display("[TB] FAIL bp_release got=%b exp=0010", readyIn); end
        tick();
        testsRun++; if ({validOut, selOut, dataOut} !== {1'b1, 2'd1, 64'h5A}) begin testsFailed++; $display("[TB] FAIL bp_next got sel=%0d d=%h exp sel=1 d=5a", selOut, dataOut); end
        applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1);
        tick();
        testsRun++; if (validOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_drain got=%b exp=0", validOut); end
    endtask

    task automatic test_reset_mid_packet();
        doReset();
        defaultData();
        applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b1);
        #1;
        testsRun++; if (readyIn !== 4'b1000) begin testsFailed++; $display("[TB] FAIL midrst_first got=%b exp=1000", readyIn); end
        tick();
        sopIn = 4'b0000;
        reset = 1'b1;
        #1;
        testsRun++; if (validOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_valid got=%b exp=0", validOut); end
        testsRun++; if (readyIn !== 4'b0000) begin testsFailed++; $display("[TB] FAIL midrst_ready got=%b exp=0000", readyIn); end
        tick();
        reset = 1'b0;
        applyStimulus(4'b1001, 4'b1001, 4'b1001, 1'b1);
        #1;
        testsRun++; if (readyIn !== 4'b0001) begin testsFailed++; $display("[TB] FAIL midrst_regrant got=%b exp=0001", readyIn); end
        tick();
        testsRun++; if ({validOut, selOut} !== 3'b100) begin testsFailed++; $display("[TB] FAIL midrst_beat0 got=%b exp=100", {validOut, selOut}); end
        tick();
        testsRun++; if ({validOut, selOut} !== 3'b111) begin testsFailed++; $display("[TB] FAIL midrst_beat3 got=%b exp=111", {validOut, selOut}); end
    endtask

    task automatic test_fairness();
        doReset();
        defaultData();
        applyStimulus(4'b1111, 4'b1111, 4'b1111, 1'b1);
        #1;
        for (int i = 0; i < 8; i++) begin
            tick();
            testsRun++; if ({validOut, selOut, dataOut} !== {1'b1, 2'(i % 4), 64'hC0DE_0000_0000_0000 + 64'(i % 4)}) begin testsFailed++; $display("[TB] FAIL fair[%0d] got v=%b sel=%0d exp sel=%0d", i, validOut, selOut, i % 4); end
        end
    endtask

    task automatic test_wrap();
        doReset();
        defaultData();
        applyStimulus(4'b0100, 4'b0100, 4'b0100, 1'b1);
        tick();
        applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b1);
        #1;
        testsRun++; if (readyIn !== 4'b1000) begin testsFailed++; $display("[TB] FAIL wrap_start got=%b exp=1000", readyIn); end
        tick();
        applyStimulus(4'b1111, 4'b0111, 4'b1111, 1'b1);
        #1;
        testsRun++; if (readyIn !== 4'b1000) begin testsFailed++; $display("[TB] FAIL wrap_locked got=%b exp=1000", readyIn); end
        tick();
        testsRun++; if ({validOut, selOut, eopOut} !== 4'b1111) begin testsFailed++; $display("[TB] FAIL wrap_eop got=%b exp=1111", {validOut, selOut, eopOut}); end
        applyStimulus(4'b1111, 4'b1111, 4'b1111, 1'b1);
        #1;
        testsRun++; if (readyIn !== 4'b0001) begin testsFailed++; $display("[TB] FAIL wrap_next got=%b exp=0001", readyIn); end
        tick();
        testsRun++; if ({validOut, selOut} !== 3'b100) begin testsFailed++; $display("[TB] FAIL wrap_beat got=%b exp=100", {validOut, selOut}); end
    endtask

    task automatic test_random();
        int pktLen[NI];
        int beatIdx[NI];
        int g;
        int accepted;
        bit canLoad;
        logic [3:0] expReady;
        doReset();
        for (int i = 0; i < NI; i++) begin
            pktLen[i]  = $urandom_range(1, 3);
            beatIdx[i] = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < NI; i++) begin
                if (!validIn[i] && ($urandom_range(0, 1) == 1)) begin
                    validIn[i] = 1'b1;
                    eopIn[i]   = (beatIdx[i] == pktLen[i] - 1);
                    sopIn[i]   = (beatIdx[i] == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                    setData(i, {$urandom, $urandom});
                end
            end
            readyOut = ($urandom_range(0, 3) != 0);
            #1;
            g        = modelPick(validIn);
            canLoad  = !mSlotValid || readyOut;
            expReady = (g >= 0 && canLoad) ? (4'b0001 << g) : 4'b0000;
            testsRun++; if (readyIn !== expReady) begin testsFailed++; $display("[TB] FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, readyIn, expReady); end
            testsRun++; if (validOut !== mSlotValid) begin testsFailed++; $display("[TB] FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, validOut, mSlotValid); end
            if (mSlotValid) begin
                testsRun++; if ({selOut, dataOut, sopOut, eopOut} !== {2'(mSlotSrc), mSlotData, mSlotSop, mSlotEop}) begin testsFailed++; $display("[TB] FAIL rand_beat cyc=%0d got sel=%0d d=%h s=%b e=%b exp sel=%0d d=%h s=%b e=%b", cyc, selOut, dataOut, sopOut, eopOut, mSlotSrc, mSlotData, mSlotSop, mSlotEop); end
            end
            if (mLocked && ((validIn & ~(4'b0001 << mOwner)) != 4'b0000)) mPerf++;
            accepted = -1;
            if (g >= 0 && canLoad) begin
                accepted   = g;
                mSlotValid = 1;
                mSlotSrc   = g;
                mSlotData  = dataIn[g*DW +: DW];
                mSlotSop   = sopIn[g];
                mSlotEop   = eopIn[g];
                if (eopIn[g]) begin
                    mLocked = 0;
                    mRr     = (g + 1) % NI;
                end else begin
                    mLocked = 1;
                    mOwner  = g;
                end
            end else if (readyOut) begin
                mSlotValid = 0;
            end
            tick();
            if (accepted >= 0) begin
                validIn[accepted] = 1'b0;
                beatIdx[accepted]++;
                if (beatIdx[accepted] == pktLen[accepted]) begin
                    beatIdx[accepted] = 0;
                    pktLen[accepted]  = $urandom_range(1, 3);
                end
            end
        end
`ifdef COMMIT_ARB_PERF_EN
        testsRun++; if (perfLockStalls !== mPerf) begin testsFailed++; $display("[TB] FAIL rand_perf got=%0d exp=%0d", perfLockStalls, mPerf); end
`endif
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        validIn     = '0;
        dataIn      = '0;
        sopIn       = '0;
        eopIn       = '0;
        readyOut    = 1'b1;
        test_reset();
        test_single_beat();
        test_lock_packet();
        test_backpressure();
        test_reset_mid_packet();
        test_fairness();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/vx_commit_lock_arb.md
VX_COMMIT_LOCK_ARB -- requirements
Module: VX_commit_lock_arb

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 4: number of execute-unit commit requesters (2..8).
REQ-002 SHALL have parameter DATAW, default 64: payload width, excluding sop/eop.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port valid_in, input, NUM_INPUTS: per-requester beat valid.
REQ-006 SHALL have port data_in, input, NUM_INPUTS*DATAW: per-requester payload.
REQ-007 SHALL have port sop_in, input, NUM_INPUTS: first beat of a multi-beat commit.
REQ-008 SHALL have port eop_in, input, NUM_INPUTS: last beat of a multi-beat commit.
REQ-009 SHALL have port ready_in, output, NUM_INPUTS: per-requester beat accepted when ready_in[i] && valid_in[i].
REQ-010 SHALL have port valid_out, output, 1: registered output beat valid.
REQ-011 SHALL have ports data_out (output, DATAW), sop_out (output, 1) and eop_out (output, 1): registered beat.
REQ-012 SHALL have port sel_out, output, clog2(NUM_INPUTS): index of the source of the current output beat.
REQ-013 SHALL have port ready_out, input, 1: downstream accept.

Function
REQ-014 SHALL implement a two-state FSM: UNLOCKED and LOCKED(owner).
REQ-015 In UNLOCKED, SHALL grant the first valid input in round-robin order starting at rr_ptr.
REQ-016 In LOCKED, SHALL consider only the owner; all other inputs SHALL see ready_in=0.
REQ-017 A beat SHALL be accepted iff its input is granted and the output slot can load, i.e. !valid_out || ready_out.
REQ-018 An accepted beat with eop=0 SHALL move the FSM to LOCKED(owner=granted index), or keep it there.
REQ-019 An accepted beat with eop=1 SHALL move the FSM to UNLOCKED and set rr_ptr=(granted+1) mod NUM_INPUTS.
REQ-020 A beat with sop=1, eop=1 is single-beat: SHALL stay UNLOCKED and advance rr_ptr.
REQ-021 sop is informational only; a beat lacking sop SHALL be handled identically.
REQ-022 Latency SHALL be 1 cycle: an accepted beat appears on the outputs the next cycle.
REQ-023 Outputs SHALL hold stable while valid_out && !ready_out; no beat is dropped or duplicated.
REQ-024 Simultaneous drain and load SHALL sustain 1 beat/cycle throughput.
REQ-025 With no valid input and the slot draining, valid_out SHALL fall next cycle; rr_ptr and the FSM SHALL be unchanged.
REQ-026 ready_in SHALL depend combinationally on valid_in, FSM state, rr_ptr, valid_out and ready_out only, never on data_in.
REQ-027 rr_ptr SHALL wrap from NUM_INPUTS-1 to 0.

Reset
REQ-028 Reset SHALL force valid_out=0, sop_out=0, eop_out=0, data_out=0, sel_out=0, state UNLOCKED and rr_ptr=0, independent of clk.
REQ-029 Reset asserted mid-packet SHALL drop the lock; the first grant after release SHALL be from rr_ptr=0.
REQ-030 ready_in SHALL be 0 while reset is asserted.

Configuration
REQ-031 With COMMIT_ARB_PERF_EN defined, SHALL add output perf_lock_stalls, 32 bits, reset 0.
REQ-032 perf_lock_stalls SHALL increment, wrapping at 2^32, each cycle the FSM is LOCKED and some non-owner input has valid_in=1.
REQ-033 Without COMMIT_ARB_PERF_EN, neither the port nor its counter SHALL exist.

Structure
REQ-034 The FSM state enum (UNLOCKED, LOCKED) SHALL be a typedef in VX_gpu_pkg.
REQ-035 Combinational round-robin selection (valid mask, pointer -> one-hot grant, index) SHALL be a sub-module, VX_rr_pick.
REQ-036 No other sub-module SHALL be instantiated; the output slot SHALL be local registers.

Verification
REQ-037 Reset, then inputs 0 and 2 valid single-beat (sop=eop=1), ready_out=1 -> outputs sel 0, then 2, then 0; rr_ptr cycles 1, 3, 1.
REQ-038 Input 1 sends a 3-beat packet (sop,-,eop) while input 0 is continuously valid -> sel_out=1 for 3 consecutive beats, then 0; with PERF_EN, perf_lock_stalls=2.
REQ-039 Hold ready_out=0 for 4 cycles with a beat 0xA5 pending -> data_out stays 0xA5, all ready_in=0, no loss; beat drains when ready_out=1.
REQ-040 Assert reset mid-packet after beat 1 of 3 from input 3 -> valid_out=0 immediately; after release, input 0 is granted before input 3.
REQ-041 All 4 inputs continuously valid single-beat, ready_out=1 -> one beat/cycle, fairness 0,1,2,3,0; no input waits more than 3 beats.
REQ-042 Input 3 eop beat accepted while rr_ptr=3 -> rr_ptr wraps to 0 and the next grant is input 0.
